// File: rtl/hwpe_dma_pkg.sv
// Shared types and constants for the hwpe DMA loader.
// Region bases mirror the hwpe memory map.
`ifndef HWPE_ADDR_WIDTH
`define HWPE_ADDR_WIDTH 16
`endif

package hwpe_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } dma_state_e;

  localparam int unsigned WORD_BYTES       = 8;
  localparam int unsigned FMEM_ADDR2_START = 32'h0000_4000;
  localparam int unsigned KMEM_ADDR_START  = 32'h0000_8000;

endpackage

// File: rtl/hwpe_dma_packer.sv
// Pairs two 32-bit beats into one 64-bit word and
// registers the resulting hwpe write strobe/address/data.
module hwpe_dma_packer #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lo_we,
  input  logic              hi_we,
  input  logic [31:0]       data,
  input  logic [ADDR_W-1:0] addr,
  output logic              wen,
  output logic [ADDR_W-1:0] wa,
  output logic [63:0]       wd
);

  logic [31:0]       lo_q, lo_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [63:0]       wd_q, wd_d;

  // Hold the low half; fire a one-cycle write on the high half.
  always_comb begin
    lo_d  = lo_q;
    wen_d = 1'b0;
    wa_d  = wa_q;
    wd_d  = wd_q;
    if (lo_we) lo_d = data;
    if (hi_we) begin
      wen_d = 1'b1;
      wa_d  = addr;
      wd_d  = {data, lo_q};
    end
  end

  // Output and low-beat registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q  <= '0;
      wen_q <= 1'b0;
      wa_q  <= '0;
      wd_q  <= '0;
    end else begin
      lo_q  <= lo_d;
      wen_q <= wen_d;
      wa_q  <= wa_d;
      wd_q  <= wd_d;
    end
  end

  assign wen = wen_q;
  assign wa  = wa_q;
  assign wd  = wd_q;

endmodule

// File: rtl/hwpe_dma_loader.sv
// Descriptor-driven feeder of the hwpe DMA write port.
// Optional running XOR checksum: HWPE_DMA_LOADER_CSUM_EN.
`ifndef HWPE_ADDR_WIDTH
`define HWPE_ADDR_WIDTH 16
`endif

module hwpe_dma_loader
  import hwpe_dma_pkg::*;
#(
  parameter int ADDR_W = `HWPE_ADDR_WIDTH,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [ADDR_W-1:0] desc_dst_addr,
  input  logic [LEN_W-1:0]  desc_len,
  input  logic              desc_last,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic [31:0]       src_data,
  output logic              dma_wen,
  output logic [ADDR_W-1:0] dma_wa,
  output logic [63:0]       dma_wd,
`ifdef HWPE_DMA_LOADER_CSUM_EN
  output logic [31:0]       csum,
`endif
  output logic              busy,
  output logic              done
);

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              rdy_en_q;
  logic              desc_acc, src_acc;

  assign desc_ready = rdy_en_q && (state_q == ST_IDLE);
  assign src_ready  = (state_q == ST_LO) || (state_q == ST_HI);
  assign desc_acc   = desc_valid && desc_ready;
  assign src_acc    = src_valid && src_ready;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;

  // Next state, address/length bookkeeping and done pulse.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    last_d  = last_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (desc_acc) begin
          addr_d = {desc_dst_addr[ADDR_W-1:3], 3'b000};
          rem_d  = desc_len;
          last_d = desc_last;
          if (desc_len == '0) done_d = desc_last;
          else state_d = ST_LO;
        end
      end
      ST_LO: begin
        if (src_acc) state_d = ST_HI;
      end
      ST_HI: begin
        if (src_acc) begin
          addr_d = addr_q + ADDR_W'(WORD_BYTES);
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = last_q;
          end else begin
            state_d = ST_LO;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state registers; desc_ready is held low during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      last_q   <= last_d;
      done_q   <= done_d;
      rdy_en_q <= 1'b1;
    end
  end

  hwpe_dma_packer #(
    .ADDR_W (ADDR_W)
  ) u_packer (
    .clk   (clk),
    .rst_n (rst_n),
    .lo_we (src_acc && (state_q == ST_LO)),
    .hi_we (src_acc && (state_q == ST_HI)),
    .data  (src_data),
    .addr  (addr_q),
    .wen   (dma_wen),
    .wa    (dma_wa),
    .wd    (dma_wd)
  );

`ifdef HWPE_DMA_LOADER_CSUM_EN
  logic [31:0] csum_q, csum_d;

  // Running XOR of accepted beats, cleared per descriptor.
  always_comb begin
    csum_d = csum_q;
    if (desc_acc) csum_d = '0;
    else if (src_acc) csum_d = csum_q ^ src_data;
  end

  // Checksum register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum_q <= '0;
    else csum_q <= csum_d;
  end

  assign csum = csum_q;
`endif

endmodule

// File: tb/tb_hwpe_dma_loader.sv
// Self-checking bench for hwpe_dma_loader.
// Randomized transfers are checked against a queue model.
module tb_hwpe_dma_loader;
  import hwpe_dma_pkg::*;

  localparam int AW = 16;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          desc_valid = 1'b0;
  logic          desc_ready;
  logic [AW-1:0] desc_dst_addr = '0;
  logic [LW-1:0] desc_len = '0;
  logic          desc_last = 1'b0;
  logic          src_valid = 1'b0;
  logic          src_ready;
  logic [31:0]   src_data = '0;
  logic          dma_wen;
  logic [AW-1:0] dma_wa;
  logic [63:0]   dma_wd;
  logic          busy;
  logic          done;
`ifdef HWPE_DMA_LOADER_CSUM_EN
  logic [31:0]   csum;
`endif

  hwpe_dma_loader #(.ADDR_W(AW), .LEN_W(LW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .desc_valid    (desc_valid),
    .desc_ready    (desc_ready),
    .desc_dst_addr (desc_dst_addr),
    .desc_len      (desc_len),
    .desc_last     (desc_last),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .src_data      (src_data),
    .dma_wen       (dma_wen),
    .dma_wa        (dma_wa),
    .dma_wd        (dma_wd),
`ifdef HWPE_DMA_LOADER_CSUM_EN
    .csum          (csum),
`endif
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] wa;
    logic [63:0]   wd;
    logic          dn;
  } wr_t;

  wr_t         obs[$];
  logic [31:0] beats[$];
  int          done_cnt = 0;
  int          cyc = 0;
  int          n_pass = 0;
  int          n_tot = 0;
  logic [31:0] csum_at_done = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every write and done pulse seen on the DUT outputs.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dma_wen) obs.push_back('{dma_wa, dma_wd, done});
      if (done) begin
        done_cnt++;
`ifdef HWPE_DMA_LOADER_CSUM_EN
        csum_at_done = csum;
`endif
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] o,
                     input logic [63:0] e);
    n_tot++;
    assert (o === e) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, o, e);
  endtask

  task automatic send_desc(input logic [AW-1:0] a, input int len,
                           input bit last, output int c);
    int n;
    @(negedge clk);
    desc_valid    = 1'b1;
    desc_dst_addr = a;
    desc_len      = LW'(len);
    desc_last     = last;
    n = 0;
    while (!desc_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("desc_timeout", 1, 0);
    @(posedge clk);
    #1;
    c = cyc;
    desc_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input int gap,
                           output int c);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    src_valid = 1'b1;
    src_data  = d;
    n = 0;
    while (!src_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("src_timeout", 1, 0);
    @(posedge clk);
    #1;
    c = cyc;
    src_valid = 1'b0;
  endtask

  // Drive one descriptor with the beats queue and compare against model.
  task automatic run_xfer(input logic [AW-1:0] a, input int len,
                          input bit last, input int gapmax,
                          input string tag);
    int c;
    logic [AW-1:0] ea;
    obs.delete();
    done_cnt = 0;
    send_desc(a, len, last, c);
    foreach (beats[i])
      send_beat(beats[i], $urandom_range(gapmax, 0), c);
    repeat (3) @(negedge clk);
    chk({tag, "_nwr"}, 64'(obs.size()), 64'(len));
    for (int i = 0; i < len && i < obs.size(); i++) begin
      ea = AW'((int'(a) / 8) * 8 + 8 * i);
      chk({tag, "_wa"}, 64'(obs[i].wa), 64'(ea));
      chk({tag, "_wd"}, obs[i].wd, {beats[2*i+1], beats[2*i]});
      chk({tag, "_dn"}, 64'(obs[i].dn), 64'(last && i == len - 1));
    end
    chk({tag, "_done"}, 64'(done_cnt), 64'(last));
  endtask

  initial begin
    int c, ca, cb, len;
    bit last;
    logic [31:0] x;

    // Reset state.
    #2;
    chk("rst_desc_ready", 64'(desc_ready), 0);
    chk("rst_src_ready", 64'(src_ready), 0);
    chk("rst_wen", 64'(dma_wen), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_desc_ready", 64'(desc_ready), 1);
    chk("idle_src_ready", 64'(src_ready), 0);

    // Basic two-word transfer.
    beats = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    run_xfer(16'h0000, 2, 1'b1, 0, "basic");
    chk("basic_wd0", obs.size() > 0 ? obs[0].wd : 64'hx,
        64'h2222222211111111);
`ifdef HWPE_DMA_LOADER_CSUM_EN
    chk("csum", 64'(csum_at_done), 64'(32'h11111111 ^ 32'h22222222 ^
        32'h33333333 ^ 32'h44444444));
`endif

    // Unaligned start address in fmap SRAM2.
    beats = '{32'hA5A5A5A5, 32'h5A5A5A5A};
    run_xfer(AW'(FMEM_ADDR2_START + 5), 1, 1'b0, 0, "align");

    // Five-cycle stall between the LO and HI beats.
    obs.delete();
    send_desc(16'h0100, 1, 1'b0, c);
    send_beat(32'hCAFEF00D, 0, c);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_wen", 64'(dma_wen), 0);
      chk("stall_busy", 64'(busy), 1);
    end
    send_beat(32'hDEADBEEF, 0, c);
    @(negedge clk);
    chk("stall_wen_hi", 64'(dma_wen), 1);
    chk("stall_wd", dma_wd, 64'hDEADBEEF_CAFEF00D);
    chk("stall_wa", 64'(dma_wa), 64'h0100);
    @(negedge clk);
    chk("stall_wen_pulse", 64'(dma_wen), 0);
    chk("stall_wd_hold", dma_wd, 64'hDEADBEEF_CAFEF00D);

    // Zero-length descriptor with last.
    obs.delete();
    send_desc(16'h0200, 0, 1'b1, c);
    @(negedge clk);
    chk("len0_done", 64'(done), 1);
    chk("len0_wen", 64'(dma_wen), 0);
    chk("len0_busy", 64'(busy), 0);
    @(negedge clk);
    chk("len0_done_pulse", 64'(done), 0);
    chk("len0_nwr", 64'(obs.size()), 0);

    // Address wrap.
    beats = '{32'h1, 32'h2, 32'h3, 32'h4};
    run_xfer(16'hFFF8, 2, 1'b0, 1, "wrap");

    // Back-to-back descriptors.
    obs.delete();
    send_desc(16'h0300, 1, 1'b0, c);
    fork
      begin
        send_beat(32'h0000AAAA, 1, c);
        send_beat(32'h0000BBBB, 2, ca);
      end
      begin
        @(negedge clk);
        chk("b2b_ready_busy", 64'(desc_ready), 0);
        send_desc(16'h0400, 1, 1'b1, cb);
      end
    join
    chk("b2b_gap", 64'(cb - ca), 1);
    send_beat(32'h0000CCCC, 0, c);
    send_beat(32'h0000DDDD, 0, c);
    repeat (2) @(negedge clk);
    chk("b2b_nwr", 64'(obs.size()), 2);
    if (obs.size() == 2)
      chk("b2b_wa1", 64'(obs[1].wa), 64'h0400);

    // Randomized descriptors.
    for (int t = 0; t < 6; t++) begin
      len  = $urandom_range(4, 1);
      last = 1'($urandom_range(1, 0));
      beats.delete();
      for (int i = 0; i < 2 * len; i++) beats.push_back($urandom);
      run_xfer(AW'($urandom), len, last, 2, "rand");
    end

    // Reset in the middle of word 3 of 4.
    obs.delete();
    done_cnt = 0;
    send_desc(16'h0500, 4, 1'b1, c);
    for (int i = 0; i < 5; i++) begin
      x = $urandom;
      send_beat(x, 0, c);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_wen", 64'(dma_wen), 0);
    chk("mrst_wa", 64'(dma_wa), 0);
    chk("mrst_wd", dma_wd, 0);
    chk("mrst_busy", 64'(busy), 0);
    chk("mrst_src_ready", 64'(src_ready), 0);
    chk("mrst_desc_ready", 64'(desc_ready), 0);
    obs.delete();
    done_cnt = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("mrst_nwr", 64'(obs.size()), 0);
    chk("mrst_done", 64'(done_cnt), 0);

    // Fresh transfer after reset: stale low beat must not leak.
    beats = '{32'h0BADC0DE, 32'h600DF00D};
    run_xfer(16'h0600, 1, 1'b1, 0, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
